result_pack_stage: RTL and testbench
====================================

# result_pack_stage

Parametrised final-result packing stage for the FPU datapaths (natural logarithm, add/sub, multiply). It takes sign, exponent and significand from the last arithmetic phase plus overflow, underflow and invalid indicators. It substitutes the IEEE-754 special encodings, assembles the W-bit word, and delivers it through a 2-entry valid/ready buffer so downstream back-pressure never stalls the datapath mid-word. It replaces fixed single- and double-precision special-case constants with values derived from the parameters.

## Interface
- W, 32, total word width (32 or 64).
- EW, 8, exponent width (8 or 11).
- SW, 23, stored significand width (23 or 52); W = 1+EW+SW is required.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  input bundle valid.
- in_ready_o  out  1  stage can accept a bundle this cycle.
- sign_i  in  1  sign of result.
- exp_ieee_i  in  EW  biased exponent.
- sgf_ieee_i  in  SW  significand without hidden bit.
- ovf_i  in  1  result overflowed.
- unf_i  in  1  result underflowed.
- nan_i  in  1  invalid operation.
- out_valid_o  out  1  final_result_ieee_o holds a valid word.
- out_ready_i  in  1  consumer accepts the word this cycle.
- final_result_ieee_o  out  W  packed IEEE-754 result.
- flags_clr_i  in  1  clear sticky flags (RESULT_FLAGS_EN only).
- flags_o  out  3  sticky {invalid, overflow, underflow} (RESULT_FLAGS_EN only).

## Operation
- Push happens when in_valid_i && in_ready_o. Pop happens when out_valid_o && out_ready_i.
- Packing is combinational on the input bundle and is written into the buffer on push. Priority is nan_i > ovf_i > unf_i > normal.
  - NaN: quiet NaN {1'b0, all-ones EW, 1'b1, (SW-1) zeros}. sign_i is ignored.
  - Overflow: infinity {sign_i, all-ones EW, SW zeros}.
  - Underflow: signed zero {sign_i, EW zeros, SW zeros}.
  - Normal: {sign_i, exp_ieee_i, sgf_ieee_i}, unchanged.
- Buffer: 2 entries, FIFO order, a count register of 0..2, and read/write pointers of 1 bit each that wrap.
  - in_ready_o = (count != 2).
  - out_valid_o = (count != 0).
  - final_result_ieee_o = entry at the read pointer.
- Simultaneous push and pop leave count unchanged and advance both pointers. Push at count 2 is impossible because in_ready_o is 0. Pop at count 0 is impossible because out_valid_o is 0.
- Bundles presented while in_ready_o=0 are ignored and must be held by the producer.

## Timing
- Latency: a push in cycle N gives out_valid_o=1 in cycle N+1 with that word at the head.
- Throughput: 1 word/cycle while out_ready_i=1.
- in_ready_o depends only on registered count, with no combinational path from out_ready_i. After a pop from count 2, in_ready_o rises the following cycle.
- Reset values (asynchronous, immediate on rst=1):
  - count=0, pointers=0.
  - out_valid_o=0, in_ready_o=1.
  - final_result_ieee_o=0, flags_o=0.
  - Buffered words are discarded.
- Reset mid-transfer: the word in flight is lost. The first push after rst deasserts behaves as from idle.
- Flags: each push sets the flag bits of its bundle under the same priority; only one flag is set per push. flags_clr_i clears all flags the next edge. When a clear and a set occur in the same cycle, the set wins for that bit.

## Configuration
- RESULT_FLAGS_EN defined: the sticky flag register, flags_clr_i and flags_o exist as described.
- RESULT_FLAGS_EN undefined: the flag register is not built, flags_o is tied to 3'b000, and flags_clr_i is ignored. Packing and buffering are identical in both builds.

## Structure
- The shared package fpu_pack_pkg holds:
  - flag bit index constants (FLAG_NV=2, FLAG_OF=1, FLAG_UF=0);
  - a packed-result struct typedef;
  - functions that return all-ones exponent, qNaN and infinity patterns parameterised by EW and SW.
- One sub-module, pack_skid_buf (parameter W): the 2-entry buffer with count and pointers.
- The top level holds the special-value mux, the flag register and the instantiation of pack_skid_buf.

## Test plan
- Normal (W=32): sign 1, exp 0x80, sgf 0x400000, no flags, out_ready_i=1 -> 0xC0400000 the cycle after the push; flags_o=0.
- Specials (W=32): ovf, sign 0 -> 0x7F800000. ovf, sign 1 -> 0xFF800000. unf, sign 1 -> 0x80000000. nan+ovf, sign 1 -> 0x7FC00000 with flags_o=3'b100.
- Double (W=64, EW=11, SW=52): ovf, sign 0 -> 0x7FF0000000000000. nan -> 0x7FF8000000000000.
- Back-pressure: out_ready_i=0 with pushes of A, B, C -> in_ready_o=0 after A and B; C is held. Raising out_ready_i yields A, B, C in order with no loss or duplication.
- Streaming: continuous in_valid_i and out_ready_i for 16 words -> one word per cycle and in_ready_o stays 1.
- Reset and flags: rst asserted with 2 words buffered -> out_valid_o=0 and flags_o=0 immediately. With flags_clr_i and a ovf push in the same cycle -> flags_o=3'b010.

Source files
------------

// File: rtl/fpu_pack_pkg.sv
// Shared definitions for the FPU result packing stage.
// - FLAG_* : bit positions of {invalid, overflow, underflow} in the flag vector
// - res_kind_t / pack_res_t : which special encoding a bundle selects, plus its flag bits
// - exp_ones_pat / inf_pat / qnan_pat : special encodings built from EW and SW, returned
//   right-aligned in 64 bits with the sign bit clear; callers keep the low W bits
package fpu_pack_pkg;

    localparam int unsigned FLAG_NV = 2;
    localparam int unsigned FLAG_OF = 1;
    localparam int unsigned FLAG_UF = 0;

    typedef enum logic [1:0] {
        KindNorm = 2'd0,
        KindUf   = 2'd1,
        KindOf   = 2'd2,
        KindNan  = 2'd3
    } res_kind_t;

    typedef struct packed {
        res_kind_t  kind;
        logic [2:0] flags;
    } pack_res_t;

    // All-ones exponent field placed above an SW-bit significand.
    function automatic logic [63:0] exp_ones_pat(input int unsigned ew, input int unsigned sw);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < ew; i++) begin
            r[sw + i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [63:0] inf_pat(input int unsigned ew, input int unsigned sw);
        return exp_ones_pat(ew, sw);
    endfunction

    // Quiet NaN: all-ones exponent with the top significand bit set.
    function automatic logic [63:0] qnan_pat(input int unsigned ew, input int unsigned sw);
        return exp_ones_pat(ew, sw) | (64'd1 << (sw - 1));
    endfunction

endpackage

// File: rtl/result_pack_stage_if.sv
// Handshake and data bundle of result_pack_stage.
// master: producer/consumer side (drives the input bundle, out_ready_i, flags_clr_i)
// slave : the packing stage
interface result_pack_stage_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned EW = 8,
    parameter int unsigned SW = 23
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic          sign_i;
    logic [EW-1:0] exp_ieee_i;
    logic [SW-1:0] sgf_ieee_i;
    logic          ovf_i;
    logic          unf_i;
    logic          nan_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  final_result_ieee_o;
    logic          flags_clr_i;
    logic [2:0]    flags_o;

    modport master (
        output in_valid_i, sign_i, exp_ieee_i, sgf_ieee_i, ovf_i, unf_i, nan_i,
        output out_ready_i, flags_clr_i,
        input  in_ready_o, out_valid_o, final_result_ieee_o, flags_o
    );

    modport slave (
        input  in_valid_i, sign_i, exp_ieee_i, sgf_ieee_i, ovf_i, unf_i, nan_i,
        input  out_ready_i, flags_clr_i,
        output in_ready_o, out_valid_o, final_result_ieee_o, flags_o
    );
endinterface

// File: rtl/pack_skid_buf.sv
// Two-entry FIFO buffer with valid/ready on both sides.
// Ports: clk, rst (async, active-high); in_valid_i/in_ready_o/data_i write side;
// out_valid_o/out_ready_i/data_o read side (data_o is the head entry).
// in_ready_o comes only from the registered count, so there is no path from out_ready_i.
module pack_skid_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   count_q, count_d;
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic         push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign data_o      = mem_q[rptr_q];

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) wptr_d = ~wptr_q;
        if (pop)  rptr_d = ~rptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            if (push) mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/result_pack_stage.sv
// Final-result packing stage: substitutes IEEE-754 special encodings (priority
// nan > ovf > unf > normal), assembles the W-bit word and buffers it in pack_skid_buf.
// Ports: clk, rst (async, active-high); bus_io (result_pack_stage_if.slave) carries the
// input bundle, in/out handshakes, final_result_ieee_o and the flag signals.
// Optional feature macro RESULT_FLAGS_EN: builds the sticky {nv, of, uf} flag register;
// without it flags_o is 3'b000 and flags_clr_i is ignored.
module result_pack_stage
    import fpu_pack_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned EW = 8,
    parameter int unsigned SW = 23
) (
    input  logic                clk,
    input  logic                rst,
    result_pack_stage_if.slave  bus_io
);

    localparam logic [63:0]  QNAN64 = qnan_pat(EW, SW);
    localparam logic [63:0]  INF64  = inf_pat(EW, SW);
    localparam logic [W-1:0] QNAN   = QNAN64[W-1:0];
    localparam logic [W-1:0] INF    = INF64[W-1:0];

    pack_res_t    res;
    logic [W-1:0] word;
    logic         push;

    always_comb begin
        res.kind  = KindNorm;
        res.flags = '0;
        if (bus_io.nan_i) begin
            res.kind           = KindNan;
            res.flags[FLAG_NV] = 1'b1;
        end else if (bus_io.ovf_i) begin
            res.kind           = KindOf;
            res.flags[FLAG_OF] = 1'b1;
        end else if (bus_io.unf_i) begin
            res.kind           = KindUf;
            res.flags[FLAG_UF] = 1'b1;
        end
    end

    always_comb begin
        word = {bus_io.sign_i, bus_io.exp_ieee_i, bus_io.sgf_ieee_i};
        unique case (res.kind)
            KindNan: word = QNAN;  // sign ignored: canonical positive qNaN
            KindOf:  word = {bus_io.sign_i, INF[W-2:0]};
            KindUf:  word = {bus_io.sign_i, {(W-1){1'b0}}};
            default: word = {bus_io.sign_i, bus_io.exp_ieee_i, bus_io.sgf_ieee_i};
        endcase
    end

    assign push = bus_io.in_valid_i & bus_io.in_ready_o;

    pack_skid_buf #(
        .W (W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus_io.in_valid_i),
        .in_ready_o  (bus_io.in_ready_o),
        .data_i      (word),
        .out_valid_o (bus_io.out_valid_o),
        .out_ready_i (bus_io.out_ready_i),
        .data_o      (bus_io.final_result_ieee_o)
    );

`ifdef RESULT_FLAGS_EN
    logic [2:0] flags_q, flags_d;

    // Clear first, then OR in this push's flag so a same-cycle set wins.
    always_comb begin
        flags_d = flags_q;
        if (bus_io.flags_clr_i) flags_d = '0;
        if (push) flags_d = flags_d | res.flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_d;
    end

    assign bus_io.flags_o = flags_q;
`else
    logic unused_flags;
    assign unused_flags   = ^{bus_io.flags_clr_i, res.flags, push};
    assign bus_io.flags_o = 3'b000;
`endif

endmodule

// File: tb/tb_result_pack_stage.sv
module tb_result_pack_stage;

`ifdef RESULT_FLAGS_EN
    localparam logic [2:0] FLAG_MASK = 3'b111;
`else
    localparam logic [2:0] FLAG_MASK = 3'b000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    result_pack_stage_if #(.W(32), .EW(8), .SW(23)) bus32 ();
    result_pack_stage_if #(.W(64), .EW(11), .SW(52)) bus64 ();

    result_pack_stage #(.W(32), .EW(8), .SW(23)) dut32 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus32)
    );

    result_pack_stage #(.W(64), .EW(11), .SW(52)) dut64 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus64)
    );

    task automatic drive32(input logic s, input logic [7:0] e, input logic [22:0] g,
                           input logic o, input logic u, input logic n);
        bus32.in_valid_i = 1'b1;
        bus32.sign_i     = s;
        bus32.exp_ieee_i = e;
        bus32.sgf_ieee_i = g;
        bus32.ovf_i      = o;
        bus32.unf_i      = u;
        bus32.nan_i      = n;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus32.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus32.out_valid_o);
        end
        checks++;
        if (bus32.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus32.in_ready_o);
        end
        checks++;
        if (bus32.final_result_ieee_o !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h expected 0", bus32.final_result_ieee_o);
        end
        checks++;
        if (bus32.flags_o !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", bus32.flags_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal;
        bus32.out_ready_i = 1'b1;
        drive32(1'b1, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus32.in_valid_i = 1'b0;
        checks++;
        if (bus32.out_valid_o !== 1'b1) begin
            errors++; $display("FAIL normal_valid: got %b expected 1", bus32.out_valid_o);
        end
        checks++;
        if (bus32.final_result_ieee_o !== 32'hC040_0000) begin
            errors++;
            $display("FAIL normal_word: got %h expected C0400000", bus32.final_result_ieee_o);
        end
        checks++;
        if (bus32.flags_o !== 3'b000) begin
            errors++; $display("FAIL normal_flags: got %b expected 000", bus32.flags_o);
        end
        @(negedge clk);
        checks++;
        if (bus32.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL normal_drain: got %b expected 0", bus32.out_valid_o);
        end
    endtask

    task automatic test_specials;
        logic        s_v [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0]  onf [4] = '{3'b100, 3'b100, 3'b010, 3'b101};  // {ovf, unf, nan}
        logic [31:0] exp_w [4] = '{32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000};
        logic [2:0]  exp_f [4] = '{3'b010, 3'b010, 3'b001, 3'b100};
        bus32.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus32.flags_clr_i = 1'b1;
            @(negedge clk);
            bus32.flags_clr_i = 1'b0;
            drive32(s_v[i], 8'h12, 23'h345, onf[i][2], onf[i][1], onf[i][0]);
            @(negedge clk);
            bus32.in_valid_i = 1'b0;
            checks++;
            if (bus32.final_result_ieee_o !== exp_w[i]) begin
                errors++;
                $display("FAIL special_word[%0d]: got %h expected %h", i,
                         bus32.final_result_ieee_o, exp_w[i]);
            end
            checks++;
            if (bus32.flags_o !== (exp_f[i] & FLAG_MASK)) begin
                errors++;
                $display("FAIL special_flags[%0d]: got %b expected %b", i, bus32.flags_o,
                         exp_f[i] & FLAG_MASK);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_double;
        bus64.out_ready_i = 1'b1;
        bus64.in_valid_i  = 1'b1;
        bus64.sign_i      = 1'b0;
        bus64.exp_ieee_i  = 11'h123;
        bus64.sgf_ieee_i  = 52'h1;
        bus64.ovf_i       = 1'b1;
        bus64.unf_i       = 1'b0;
        bus64.nan_i       = 1'b0;
        @(negedge clk);
        checks++;
        if (bus64.final_result_ieee_o !== 64'h7FF0_0000_0000_0000) begin
            errors++;
            $display("FAIL double_inf: got %h expected 7FF0000000000000",
                     bus64.final_result_ieee_o);
        end
        bus64.ovf_i  = 1'b0;
        bus64.nan_i  = 1'b1;
        bus64.sign_i = 1'b1;
        @(negedge clk);
        bus64.in_valid_i = 1'b0;
        checks++;
        if (bus64.final_result_ieee_o !== 64'h7FF8_0000_0000_0000) begin
            errors++;
            $display("FAIL double_nan: got %h expected 7FF8000000000000",
                     bus64.final_result_ieee_o);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure;
        bus32.out_ready_i = 1'b0;
        drive32(1'b0, 8'h01, 23'h00000A, 1'b0, 1'b0, 1'b0);  // A = 0x0080000A
        @(negedge clk);
        checks++;
        if (bus32.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL bp_ready_after_a: got %b expected 1", bus32.in_ready_o);
        end
        drive32(1'b0, 8'h02, 23'h00000B, 1'b0, 1'b0, 1'b0);  // B = 0x0100000B
        @(negedge clk);
        checks++;
        if (bus32.in_ready_o !== 1'b0) begin
            errors++; $display("FAIL bp_ready_after_b: got %b expected 0", bus32.in_ready_o);
        end
        drive32(1'b0, 8'h03, 23'h00000C, 1'b0, 1'b0, 1'b0);  // C = 0x0180000C, held
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus32.in_ready_o !== 1'b0 || bus32.final_result_ieee_o !== 32'h0080_000A) begin
            errors++;
            $display("FAIL bp_hold: got ready=%b word=%h expected ready=0 word=0080000A",
                     bus32.in_ready_o, bus32.final_result_ieee_o);
        end
        bus32.out_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus32.in_ready_o !== 1'b1 || bus32.final_result_ieee_o !== 32'h0100_000B) begin
            errors++;
            $display("FAIL bp_second: got ready=%b word=%h expected ready=1 word=0100000B",
                     bus32.in_ready_o, bus32.final_result_ieee_o);
        end
        @(negedge clk);
        bus32.in_valid_i = 1'b0;
        checks++;
        if (bus32.out_valid_o !== 1'b1 || bus32.final_result_ieee_o !== 32'h0180_000C) begin
            errors++;
            $display("FAIL bp_third: got valid=%b word=%h expected valid=1 word=0180000C",
                     bus32.out_valid_o, bus32.final_result_ieee_o);
        end
        @(negedge clk);
        checks++;
        if (bus32.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_empty: got %b expected 0", bus32.out_valid_o);
        end
    endtask

    task automatic test_stream;
        logic [31:0] w;
        bus32.out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive32(1'b0, 8'(i + 1), 23'(i * 3), 1'b0, 1'b0, 1'b0);
            w = {1'b0, 8'(i + 1), 23'(i * 3)};
            @(negedge clk);
            checks++;
            if (bus32.out_valid_o !== 1'b1 || bus32.in_ready_o !== 1'b1 ||
                bus32.final_result_ieee_o !== w) begin
                errors++;
                $display("FAIL stream[%0d]: got valid=%b ready=%b word=%h expected 1 1 %h", i,
                         bus32.out_valid_o, bus32.in_ready_o, bus32.final_result_ieee_o, w);
            end
        end
        bus32.in_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got %b expected 0", bus32.out_valid_o);
        end
    endtask

    task automatic test_reset_flags;
        bus32.out_ready_i = 1'b0;
        drive32(1'b0, 8'h10, 23'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive32(1'b0, 8'h11, 23'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus32.in_valid_i = 1'b0;
        checks++;
        if (bus32.in_ready_o !== 1'b0) begin
            errors++; $display("FAIL rst_full: got %b expected 0", bus32.in_ready_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus32.out_valid_o !== 1'b0 || bus32.flags_o !== 3'b000 ||
            bus32.in_ready_o !== 1'b1 || bus32.final_result_ieee_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b flags=%b ready=%b word=%h expected 0 000 1 0",
                     bus32.out_valid_o, bus32.flags_o, bus32.in_ready_o,
                     bus32.final_result_ieee_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bus32.out_ready_i = 1'b1;
        drive32(1'b1, 8'h10, 23'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (bus32.final_result_ieee_o !== 32'h8000_0000 ||
            bus32.flags_o !== (3'b001 & FLAG_MASK)) begin
            errors++;
            $display("FAIL rst_first_push: got word=%h flags=%b expected 80000000 %b",
                     bus32.final_result_ieee_o, bus32.flags_o, 3'b001 & FLAG_MASK);
        end
        bus32.flags_clr_i = 1'b1;
        drive32(1'b0, 8'h10, 23'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus32.flags_clr_i = 1'b0;
        bus32.in_valid_i  = 1'b0;
        checks++;
        if (bus32.final_result_ieee_o !== 32'h7F80_0000 ||
            bus32.flags_o !== (3'b010 & FLAG_MASK)) begin
            errors++;
            $display("FAIL clr_and_set: got word=%h flags=%b expected 7F800000 %b",
                     bus32.final_result_ieee_o, bus32.flags_o, 3'b010 & FLAG_MASK);
        end
        @(negedge clk);
    endtask

    initial begin
        bus32.in_valid_i  = 1'b0;
        bus32.sign_i      = 1'b0;
        bus32.exp_ieee_i  = '0;
        bus32.sgf_ieee_i  = '0;
        bus32.ovf_i       = 1'b0;
        bus32.unf_i       = 1'b0;
        bus32.nan_i       = 1'b0;
        bus32.out_ready_i = 1'b0;
        bus32.flags_clr_i = 1'b0;
        bus64.in_valid_i  = 1'b0;
        bus64.sign_i      = 1'b0;
        bus64.exp_ieee_i  = '0;
        bus64.sgf_ieee_i  = '0;
        bus64.ovf_i       = 1'b0;
        bus64.unf_i       = 1'b0;
        bus64.nan_i       = 1'b0;
        bus64.out_ready_i = 1'b0;
        bus64.flags_clr_i = 1'b0;
        test_reset();
        test_normal();
        test_specials();
        test_double();
        test_back_pressure();
        test_stream();
        test_reset_flags();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
